// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: dcache has priority, a streak counter forces a fetch through.
// One transaction in flight; all outputs registered; requester rdy pulses one cycle after mem_rdy.
module mem_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [1:0]  dcache_ws,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  output logic [31:0] dcache_rdata,
  output logic        dcache_rdy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_ws,
  output logic        mem_wr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  localparam logic [7:0] SMAX = 8'(DSTREAK_MAX);

  state_t     state, state_nxt;
  logic [7:0] streak;
  logic       icache_wins;
  logic       grant_i, grant_d, done;

  // A waiting fetch overrides dcache only once the dcache streak has reached the limit.
  assign icache_wins = icache_req &&
                       (!dcache_req || ((SMAX != 8'd0) && (streak == SMAX)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (icache_wins) begin
          grant_i   = 1'b1;
          state_nxt = GRANT_I;
        end else if (dcache_req) begin
          grant_d   = 1'b1;
          state_nxt = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_rdy) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak       <= 8'd0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_ws       <= 2'b00;
      mem_wr       <= 1'b0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      icache_data  <= 32'd0;
      icache_rdy   <= 1'b0;
      dcache_rdata <= 32'd0;
      dcache_rdy   <= 1'b0;
    end else begin
      if (grant_i) begin
        mem_addr  <= icache_addr;
        mem_wdata <= 32'd0;
        mem_ws    <= 2'b10;
        mem_wr    <= 1'b0;
        mem_req   <= 1'b1;
        busy      <= 1'b1;
        streak    <= 8'd0;
      end
      if (grant_d) begin
        mem_addr  <= dcache_addr;
        mem_wdata <= dcache_wdata;
        mem_ws    <= dcache_ws;
        mem_wr    <= dcache_wr;
        mem_req   <= 1'b1;
        busy      <= 1'b1;
        if (!icache_req)         streak <= 8'd0;
        else if (streak != SMAX) streak <= streak + 8'd1;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == GRANT_I) begin
          icache_data <= mem_rdata;
          icache_rdy  <= 1'b1;
        end else begin
          dcache_rdata <= mem_rdata;
          dcache_rdy   <= 1'b1;
        end
      end
      if (state == RESP) begin
        icache_rdy <= 1'b0;
        dcache_rdy <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

endmodule
